opb_register_simulink2ppc_snap: RTL
===================================

// Module: opb_register_simulink2ppc_snap
// PURPOSE
//  Fabric-to-PowerPC readback register: the reverse direction of the ppc2simulink control registers.
//  User logic presents a 32-bit word with a valid strobe. The block snapshots it and exposes it as an OPB slave.
//  Also exposes a status word (new-data flag, saturating overrun count) and a write-only clear control.
//  Single clock domain: user logic runs on OPB_Clk.
// PARAMETERS
//  C_BASEADDR    32'h010B2300  first byte address decoded
//  C_HIGHADDR    32'h010B23FF  last byte address decoded
//  C_OPB_AWIDTH  32            OPB address width
//  C_OPB_DWIDTH  32            OPB data width
//  C_FAMILY      "virtex5"     target family (informational)
// PORTS
//  OPB_Clk         in   1      sole clock
//  OPB_Rst_n       in   1      asynchronous active-low reset
//  OPB_ABus        in   [0:31] address
//  OPB_BE          in   [0:3]  byte enables; BE[3] = bits [24:31]
//  OPB_DBus        in   [0:31] write data
//  OPB_RNW         in   1      1=read, 0=write
//  OPB_select      in   1      transfer request
//  OPB_seqAddr     in   1      ignored
//  Sl_DBus         out  [0:31] read data; 0 whenever Sl_xferAck=0 (wired-OR bus)
//  Sl_xferAck      out  1      one-cycle transfer acknowledge
//  Sl_errAck       out  1      tied 0
//  Sl_retry        out  1      tied 0
//  Sl_toutSup      out  1      tied 0
//  user_data_in    in   [31:0] fabric word
//  user_valid      in   1      capture strobe
//  user_new_data   out  1      mirror of status new_data flag
// BEHAVIOUR
//  Clock/reset: one clock, OPB_Clk. Reset OPB_Rst_n is asynchronous, active-low.
//  Reset: Sl_DBus=0, Sl_xferAck=0, data_reg=0, new_data=0, ovr_cnt=0, FSM=IDLE.
//  Address map (offset = OPB_ABus - C_BASEADDR; hit = select && C_BASEADDR<=ABus<=C_HIGHADDR):
//   0x0 DATA   RO  data_reg
//   0x4 STATUS RO  [31]=new_data (OPB bit 0), [15:0]=ovr_cnt, other bits 0
//   0x8 CTRL   WO  write with BE[3]=1 and DBus[31]=1 clears ovr_cnt
//   other offsets: read 0, write ignored; still acked.
//  FSM IDLE->ACK->WAIT->IDLE:
//   IDLE: hit -> ACK.
//   ACK: Sl_xferAck=1 for exactly one cycle; Sl_DBus = registered read mux (reads only); side effects commit -> WAIT.
//   WAIT: stay until OPB_select=0, then IDLE. Guarantees one ack per select assertion.
//   Latency: ack in the 2nd cycle of select. Writes to RO offsets are acked and have no effect.
//  Capture: user_valid=1 -> data_reg<=user_data_in, new_data<=1 next edge.
//   If new_data was already 1 -> ovr_cnt+1, saturating at 16'hFFFF.
//  DATA read ack clears new_data.
//  Simultaneous events (same edge):
//   DATA read ack + user_valid: bus returns the old data_reg; new_data stays 1; no overrun counted.
//   CTRL clear + overrun increment: clear wins (ovr_cnt=0).
//  Reset mid-transfer: Sl_xferAck/Sl_DBus drop to 0 immediately; FSM returns to IDLE; the master times out.
// STRUCTURE
//  Package opb_reg_pkg: offset constants (DATA/STATUS/CTRL), state enum {IDLE,ACK,WAIT}, OVR_W=16.
//  Sub-module opb_slave_handshake: owns address hit decode and the IDLE/ACK/WAIT FSM.
//   Outputs: ack pulse, rd_strobe, wr_strobe, offset. Reusable by other readback registers.
//  Top level holds data_reg, new_data, ovr_cnt and the read mux.
// TESTING
//  1. Reset, then read 0x0 and 0x4 -> both return 0; each acked once, 2nd cycle of select.
//  2. user_valid with 32'hDEADBEEF -> STATUS reads 0x80000000.
//     Then DATA read returns 0xDEADBEEF; next STATUS read 0x00000000.
//  3. Three user_valid pulses without a read -> STATUS [15:0]=2.
//     Write 0x8 with DBus=1, BE=4'b0001 -> STATUS [15:0]=0.
//  4. Force ovr_cnt=16'hFFFE; issue 3 overruns -> reads 16'hFFFF; no wrap.
//  5. user_valid(0x1234) on the same edge as a DATA ack holding 0xAAAA ->
//     bus returns 0xAAAA; new_data=1; next DATA read returns 0x1234.
//  6. Hold select 5 cycles -> exactly one ack; address outside the range -> no ack and Sl_DBus=0.
//     Assert OPB_Rst_n=0 during ACK -> ack drops asynchronously.

Source files
------------

// File: rtl/opb_reg_pkg.sv
// Shared constants and types for the OPB readback registers.
// The offsets are byte offsets from the slave base address.
package opb_reg_pkg;

    localparam int OVR_W = 16;

    localparam logic [31:0] OFF_DATA   = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_CTRL   = 32'h8;

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

endpackage

// File: rtl/opb_slave_handshake.sv
// OPB slave address decode plus the IDLE/ACK/WAIT handshake.
// It acks once per select assertion, in the second cycle of select.
module opb_slave_handshake
    import opb_reg_pkg::*;
#(
    parameter int                AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = 32'h010B2300,
    parameter logic [AWIDTH-1:0] HIGHADDR = 32'h010B23FF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [0:AWIDTH-1] abus,
    input  logic              rnw,
    input  logic              select,
    output logic              start,
    output logic              ack,
    output logic              rd_strobe,
    output logic              wr_strobe,
    output logic [AWIDTH-1:0] offset
);

    state_t            state, state_nxt;
    logic [AWIDTH-1:0] addr;
    logic [AWIDTH-1:0] off_q;
    logic              rnw_q;
    logic              hit;

    assign addr = abus;
    assign hit  = select && (addr >= BASEADDR) && (addr <= HIGHADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            off_q <= '0;
            rnw_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                off_q <= addr - BASEADDR;
                rnw_q <= rnw;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = WAIT;
            WAIT:    if (!select) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign start     = (state == IDLE) && hit;
    assign ack       = (state == ACK);
    assign rd_strobe = ack && rnw_q;
    assign wr_strobe = ack && !rnw_q;
    // Live offset while idle so the read mux can be registered on the way into ACK.
    assign offset    = (state == IDLE) ? (addr - BASEADDR) : off_q;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC readback register: snapshots a user word on a valid strobe
// and exposes it, a new-data flag and a saturating overrun count over OPB.
module opb_register_simulink2ppc_snap
    import opb_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2300,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B23FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_new_data
);

    logic                    start, ack, rd_strobe, wr_strobe;
    logic [C_OPB_AWIDTH-1:0] offset;
    logic [31:0]             data_reg;
    logic                    new_data;
    logic [OVR_W-1:0]        ovr_cnt;
    logic [31:0]             rd_mux;
    logic                    data_rd, ctrl_clr, ovr_inc;
    logic                    unused_ok;

    opb_slave_handshake #(
        .AWIDTH   (C_OPB_AWIDTH),
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR)
    ) u_hs (
        .clk       (OPB_Clk),
        .rst_n     (OPB_Rst_n),
        .abus      (OPB_ABus),
        .rnw       (OPB_RNW),
        .select    (OPB_select),
        .start     (start),
        .ack       (ack),
        .rd_strobe (rd_strobe),
        .wr_strobe (wr_strobe),
        .offset    (offset)
    );

    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_DATA:   rd_mux = data_reg;
            OFF_STATUS: rd_mux = {new_data, {(31-OVR_W){1'b0}}, ovr_cnt};
            default:    rd_mux = '0;
        endcase
    end

    // OPB bit 31 is the LSB, and BE[3] covers that byte lane.
    assign data_rd  = rd_strobe && (offset == OFF_DATA);
    assign ctrl_clr = wr_strobe && (offset == OFF_CTRL) && OPB_BE[3] && OPB_DBus[31];
    // A capture landing on a DATA read ack replaces a word that was just consumed.
    assign ovr_inc  = user_valid && new_data && !data_rd && (ovr_cnt != OVR_MAX);

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            Sl_DBus  <= '0;
            data_reg <= '0;
            new_data <= 1'b0;
            ovr_cnt  <= '0;
        end else begin
            Sl_DBus <= (start && OPB_RNW) ? rd_mux : '0;
            if (user_valid) data_reg <= user_data_in;
            if (user_valid)   new_data <= 1'b1;
            else if (data_rd) new_data <= 1'b0;
            if (ctrl_clr)     ovr_cnt <= '0;
            else if (ovr_inc) ovr_cnt <= ovr_cnt + 1'b1;
        end
    end

    assign Sl_xferAck    = ack;
    assign Sl_errAck     = 1'b0;
    assign Sl_retry      = 1'b0;
    assign Sl_toutSup    = 1'b0;
    assign user_new_data = new_data;
    assign unused_ok     = &{1'b0, OPB_seqAddr, (C_FAMILY != "")};

endmodule
